// File: rtl/arp_sequencer_if.sv
// Sample-stream and quarter-sine BRAM port bundle for arp_sequencer.
// The master side drives the BRAM address/enable and the PWM sample stream.
interface arp_sequencer_if;
  logic        bram_en;
  logic [7:0]  bram_addr;
  logic [10:0] bram_dout;
  logic [10:0] sample;
  logic        sample_valid;

  modport master (
    output bram_en,
    output bram_addr,
    input  bram_dout,
    output sample,
    output sample_valid
  );

  modport slave (
    input  bram_en,
    input  bram_addr,
    output bram_dout,
    input  sample,
    input  sample_valid
  );
endinterface

// File: rtl/arp_sequencer.sv
// Quarter-sine DDS tone generator with a four-note arpeggiator.
// Define ARP_PATTERN_UPDOWN_EN for ping-pong note order; default order wraps 0..3.
module arp_sequencer #(
  parameter int unsigned DIV_BASE  = 746,
  parameter int unsigned NOTE_HOLD = 25000000
) (
  input  logic           CLK100MHZ,
  input  logic           CPU_RESETN,
  input  logic [7:0]     SW,
  input  logic           arp_toggle,
  arp_sequencer_if.master bus,
  output logic [1:0]     note,
  output logic           arp_on
);

  localparam int unsigned TW = $clog2(DIV_BASE + 256);
  localparam logic [26:0] HOLD_LAST = 27'(NOTE_HOLD - 1);

  typedef enum logic [2:0] {OFF, N0, N1, N2, N3} state_t;

  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] period_last;
  logic [7:0]    sw_q;
  logic          tick;

  logic [9:0]    phase;
  logic [9:0]    phase_next;
  logic [3:0]    step;
  logic          q_hi;
  logic          addr_vld;
  logic [10:0]   half;
  logic [10:0]   sample_next;

  state_t        state;
  state_t        state_next;
  logic [26:0]   dwell;
  logic [26:0]   dwell_next;
  logic          dwell_last;
`ifdef ARP_PATTERN_UPDOWN_EN
  logic          dir_down;
  logic          dir_down_next;
`endif

  logic          unused_dout_lsb;
  assign unused_dout_lsb = bus.bram_dout[0];

  assign bus.bram_en = CPU_RESETN;

  // Terminal value follows the SW copy latched at the previous wrap.
  assign period_last = TW'(DIV_BASE) + TW'(sw_q) - TW'(1);
  assign tick        = (tick_cnt == period_last);

  always_comb begin
    step = 4'd4;
    case (note)
      2'd1:    step = 4'd5;
      2'd2:    step = 4'd6;
      2'd3:    step = 4'd8;
      default: step = 4'd4;
    endcase
  end

  assign phase_next  = phase + {6'd0, step};
  assign half        = {1'b0, bus.bram_dout[10:1]};
  assign sample_next = q_hi ? (11'd1024 - half) : (11'd1024 + half);

  // Pipeline: tick -> address (+1) -> sample strobe (+2).
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      tick_cnt         <= '0;
      sw_q             <= '0;
      phase            <= '0;
      q_hi             <= 1'b0;
      addr_vld         <= 1'b0;
      bus.bram_addr    <= '0;
      bus.sample       <= 11'd1024;
      bus.sample_valid <= 1'b0;
    end else begin
      addr_vld         <= tick;
      bus.sample_valid <= addr_vld;
      if (tick) begin
        tick_cnt      <= '0;
        sw_q          <= SW;
        phase         <= phase_next;
        q_hi          <= phase_next[9];
        bus.bram_addr <= phase_next[8] ? ~phase_next[7:0] : phase_next[7:0];
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      if (addr_vld) begin
        bus.sample <= sample_next;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= OFF;
      dwell    <= '0;
`ifdef ARP_PATTERN_UPDOWN_EN
      dir_down <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      dwell    <= dwell_next;
`ifdef ARP_PATTERN_UPDOWN_EN
      dir_down <= dir_down_next;
`endif
    end
  end

  assign dwell_last = (dwell == HOLD_LAST);

  always_comb begin
    state_next = state;
    dwell_next = dwell;
`ifdef ARP_PATTERN_UPDOWN_EN
    dir_down_next = dir_down;
`endif
    note   = 2'd0;
    arp_on = 1'b0;

    case (state)
      OFF: begin
`ifdef ARP_PATTERN_UPDOWN_EN
        dir_down_next = 1'b0;
`endif
        if (arp_toggle) begin
          state_next = N0;
          dwell_next = '0;
        end
      end
      N0, N1, N2, N3: begin
        arp_on = 1'b1;
        // Toggle takes priority over a coincident terminal count.
        if (arp_toggle) begin
          state_next = OFF;
          dwell_next = '0;
        end else if (dwell_last) begin
          dwell_next = '0;
`ifdef ARP_PATTERN_UPDOWN_EN
          case (state)
            N0: begin
              state_next    = N1;
              dir_down_next = 1'b0;
            end
            N1: begin
              state_next = dir_down ? N0 : N2;
              if (dir_down) dir_down_next = 1'b0;
            end
            N2:      state_next = dir_down ? N1 : N3;
            default: begin
              state_next    = N2;
              dir_down_next = 1'b1;
            end
          endcase
`else
          case (state)
            N0:      state_next = N1;
            N1:      state_next = N2;
            N2:      state_next = N3;
            default: state_next = N0;
          endcase
`endif
        end else begin
          dwell_next = dwell + 27'd1;
        end
      end
      default: begin
        state_next = OFF;
        dwell_next = '0;
      end
    endcase

    case (state)
      N1:      note = 2'd1;
      N2:      note = 2'd2;
      N3:      note = 2'd3;
      default: note = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_arp_sequencer.sv
// Randomized bench for arp_sequencer against a cycle-indexed behavioural model.
module tb_arp_sequencer;

  localparam int unsigned DB = 24;
  localparam int unsigned NH = 100;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       toggle = 1'b0;
  logic [7:0] sw     = 8'd0;
  logic [1:0] note;
  logic       arp_on;

  arp_sequencer_if bus();

  function automatic logic [10:0] rom(input logic [7:0] a);
    return {a, 3'b101};
  endfunction

  assign bus.bram_dout = rom(bus.bram_addr);

  arp_sequencer #(.DIV_BASE(DB), .NOTE_HOLD(NH)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .SW        (sw),
    .arp_toggle(toggle),
    .bus       (bus),
    .note      (note),
    .arp_on    (arp_on)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cyc is the index of the current cycle since reset release.
  int unsigned cyc       = 0;
  int unsigned next_tick = DB - 1;
  int unsigned sched     = 0;
  int unsigned on_start  = 0;
  bit          sched_v   = 0;
  bit          m_on      = 0;
  bit          last_tick = 0;
  logic [9:0]  m_phase   = '0;
  logic [7:0]  pend_addr = '0;
  int          pend_sample = 1024;
  int          e_sample  = 1024;
  int          e_addr    = 0;
  int          e_note    = 0;
  bit          e_valid   = 0;
  bit          e_on      = 0;

  int          dut_cnt = 0;
  int          s_val  [4096];
  int          s_addr [4096];
  int unsigned s_cyc  [4096];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic int note_at(input int unsigned x);
    int unsigned i;
    i = (x - on_start) / NH;
`ifdef ARP_PATTERN_UPDOWN_EN
    case (i % 6)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 3;
      4: return 2;
      default: return 1;
    endcase
`else
    return int'(i % 4);
`endif
  endfunction

  function automatic int step_of(input int n);
    case (n)
      1: return 5;
      2: return 6;
      3: return 8;
      default: return 4;
    endcase
  endfunction

  always @(posedge clk) begin
    int cur;
    int h;
    if (!rst_n) begin
      cyc = 0; next_tick = DB - 1; sched_v = 0; m_on = 0; last_tick = 0;
      m_phase = '0; e_sample = 1024; e_addr = 0; e_note = 0; e_valid = 0; e_on = 0;
    end else begin
      cur = m_on ? note_at(cyc) : 0;
      last_tick = 0;
      if (cyc == next_tick) begin
        m_phase   = m_phase + 10'(step_of(cur));
        pend_addr = m_phase[8] ? ~m_phase[7:0] : m_phase[7:0];
        h = int'(rom(pend_addr)) / 2;
        pend_sample = m_phase[9] ? 1024 - h : 1024 + h;
        sched = cyc + 2; sched_v = 1;
        next_tick = cyc + DB + int'(sw);
        last_tick = 1;
      end
      if (toggle) begin
        if (m_on) m_on = 0;
        else begin m_on = 1; on_start = cyc + 1; end
      end
      cyc++;
      if (last_tick) e_addr = int'(pend_addr);
      e_valid = sched_v && (cyc == sched);
      if (e_valid) begin e_sample = pend_sample; sched_v = 0; end
      e_on   = m_on;
      e_note = m_on ? note_at(cyc) : 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst sample", int'(bus.sample), 1024);
      check("rst sample_valid", int'(bus.sample_valid), 0);
      check("rst bram_addr", int'(bus.bram_addr), 0);
      check("rst bram_en", int'(bus.bram_en), 0);
      check("rst note", int'(note), 0);
      check("rst arp_on", int'(arp_on), 0);
    end else begin
      check("sample", int'(bus.sample), e_sample);
      check("sample_valid", int'(bus.sample_valid), int'(e_valid));
      check("bram_addr", int'(bus.bram_addr), e_addr);
      check("bram_en", int'(bus.bram_en), 1);
      check("note", int'(note), e_note);
      check("arp_on", int'(arp_on), int'(e_on));
      if (bus.sample_valid) begin
        dut_cnt++;
        if (dut_cnt < 4096) begin
          s_val[dut_cnt]  = int'(bus.sample);
          s_addr[dut_cnt] = int'(bus.bram_addr);
          s_cyc[dut_cnt]  = cyc;
        end
      end
    end
  end

  task automatic step_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_toggle();
    toggle = 1'b1;
    step_cyc();
    toggle = 1'b0;
  endtask

  task automatic wait_cycle(input int unsigned target, input string name);
    int unsigned i;
    i = 0;
    while (cyc != target && i < 5000) begin
      step_cyc();
      i++;
    end
    if (cyc != target) check({name, " timeout"}, int'(cyc), int'(target));
  endtask

  task automatic wait_strobes(input int n, input string name);
    int i;
    i = 0;
    while (dut_cnt < n && i < 20000) begin
      step_cyc();
      i++;
    end
    if (dut_cnt < n) check({name, " timeout"}, dut_cnt, n);
  endtask

  initial begin
    int unsigned c;
    int pat [6];
`ifdef ARP_PATTERN_UPDOWN_EN
    pat = '{0, 1, 2, 3, 2, 1};
`else
    pat = '{0, 1, 2, 3, 0, 1};
`endif

    // Reset, free-running tone with arpeggiator off.
    repeat (3) step_cyc();
    rst_n = 1'b1;
    wait_strobes(128, "phase sweep");
    check("first strobe cycle", int'(s_cyc[1]), 25);
    check("second strobe cycle", int'(s_cyc[2]), 49);
    check("sample tick1", s_val[1], 1042);
    check("sample tick63", s_val[63], 2034);
    check("sample tick64", s_val[64], 2046);
    check("addr tick64", s_addr[64], 255);
    check("sample tick65", s_val[65], 2030);
    check("sample tick128", s_val[128], 1022);

    // SW change only affects the period after the next wrap.
    step_cyc();
    sw = 8'd10;
    wait_strobes(130, "sw change");
    check("period before wrap", int'(s_cyc[129] - s_cyc[128]), 24);
    check("period after wrap", int'(s_cyc[130] - s_cyc[129]), 34);
    sw = 8'd0;

    // Arpeggio note order.
    pulse_toggle();
    c = on_start;
    for (int k = 0; k < 6; k++) begin
      wait_cycle(c + 50 + 100 * k, "note wait");
      @(negedge clk);
      #1;
      check($sformatf("arp note %0d", k), int'(note), pat[k]);
      check("arp_on high", int'(arp_on), 1);
      #1;
    end

    // Toggle coincident with the N2 terminal count.
    pulse_toggle();
    step_cyc();
    pulse_toggle();
    wait_cycle(on_start + 299, "N2 terminal");
    toggle = 1'b1;
    step_cyc();
    toggle = 1'b0;
    @(negedge clk);
    #1;
    check("toggle wins arp_on", int'(arp_on), 0);
    check("toggle wins note", int'(note), 0);
    step_cyc();

    // Reset one cycle after a tick.
    begin
      int i;
      i = 0;
      while (!last_tick && i < 1000) begin step_cyc(); i++; end
      if (!last_tick) check("tick wait timeout", 0, 1);
    end
    rst_n = 1'b0;
    repeat (3) step_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post-reset sample", int'(bus.sample), 1024);
    check("post-reset valid", int'(bus.sample_valid), 0);
    step_cyc();

    // Randomized operation.
    for (int n = 0; n < 20000; n++) begin
      step_cyc();
      toggle = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 499) == 0) sw = 8'($urandom);
      rst_n = ($urandom_range(0, 2999) != 0);
    end
    rst_n  = 1'b1;
    toggle = 1'b0;
    repeat (5) step_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (checks %0d, failures %0d)", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/arp_sequencer.md
ARP_SEQUENCER -- requirements
Module: arp_sequencer

Interface
REQ-001 Parameter DIV_BASE, default 746, base sample-period in clock cycles.
REQ-002 Parameter NOTE_HOLD, default 25000000, clock cycles each arpeggio note is held (27-bit counter).
REQ-003 CLK100MHZ  in  1  system clock; reset is asynchronous and active-low.
REQ-004 CPU_RESETN  in  1  asynchronous active-low reset.
REQ-005 SW  in  8  pitch offset added to DIV_BASE.
REQ-006 arp_toggle  in  1  debounced single-cycle pulse; toggles arpeggiator on/off.
REQ-007 bram_en  out  1  quarter-sine BRAM enable.
REQ-008 bram_addr  out  8  quarter-sine BRAM address.
REQ-009 bram_dout  in  11  BRAM read data, valid 1 cycle after bram_addr is registered.
REQ-010 sample  out  11  full-wave sample for the PWM stage, offset-binary, midscale 1024.
REQ-011 sample_valid  out  1  one-cycle strobe when sample updates.
REQ-012 note  out  2  current note index (for LEDs).
REQ-013 arp_on  out  1  arpeggiator enabled.

Function
REQ-014 Sample-tick counter shall count 0..(DIV_BASE+SW-1) and assert an internal tick on the terminal value, then wrap to 0; the SW value shall be sampled at each wrap.
REQ-015 A 10-bit phase accumulator shall add step[note] on each tick, wrapping modulo 1024; steps shall be 4, 5, 6, 8 for note 0..3 (root, major third, fifth, octave).
REQ-016 Quadrant q = phase[9:8]; bram_addr shall be phase[7:0] when q[0]=0 and bitwise-inverted phase[7:0] when q[0]=1, registered on the cycle after tick.
REQ-017 On the second cycle after tick, sample shall be 1024 + bram_dout[10:1] when q[1]=0 and 1024 - bram_dout[10:1] when q[1]=1, using q latched at the tick; sample_valid shall pulse in the same cycle.
REQ-018 Tick-to-sample_valid latency shall be exactly 2 cycles; sample shall hold between strobes.
REQ-019 FSM states OFF, N0, N1, N2, N3; OFF forces note=0 and arp_on=0.
REQ-020 arp_toggle in OFF shall go to N0 with dwell counter cleared; arp_toggle in any Nx shall go to OFF.
REQ-021 In Nx, dwell counter shall count 0..NOTE_HOLD-1; at terminal count the FSM shall advance to the next note per REQ-026 and clear the counter.
REQ-022 arp_toggle coinciding with dwell terminal count: toggle wins (go to OFF, no note advance).
REQ-023 Note changes shall not reset the phase accumulator; new step applies from the next tick.
REQ-024 bram_en shall be 1 whenever CPU_RESETN is high.

Reset
REQ-025 While CPU_RESETN=0: FSM=OFF, note=0, arp_on=0, phase=0, tick and dwell counters=0, bram_addr=0, bram_en=0, sample=1024, sample_valid=0; deassertion mid-operation restarts from this state with no spurious sample_valid.

Configuration
REQ-026 Macro ARP_PATTERN_UPDOWN_EN: defined -> note order 0,1,2,3,2,1,0,... (ping-pong, direction flag cleared by reset/OFF); undefined -> 0,1,2,3,0,... (wrap).

Verification
REQ-027 Reset held then released, SW=0, arp off -> ticks every 746 cycles, sample_valid 2 cycles after each, phase +4 per tick, full period 256 ticks (190976 cycles).
REQ-028 Phase crossing 255->256 -> bram_addr goes 255 then 255 (inverted index 0); with bram_dout=2047 in q=0, sample=2047; in q=2, sample=1.
REQ-029 SW=8'd10 -> tick period 756 cycles, change taking effect only after current tick-counter wrap.
REQ-030 arp_toggle pulse, NOTE_HOLD=100 -> arp_on=1, note steps 0,1,2,3,0 every 100 cycles (with ARP_PATTERN_UPDOWN_EN: 0,1,2,3,2,1,0), phase step changes accordingly.
REQ-031 arp_toggle on same cycle as dwell terminal count in N2 -> next state OFF, note=0, arp_on=0.
REQ-032 CPU_RESETN asserted 1 cycle after a tick -> no sample_valid, sample=1024, all counters 0 after release.
